// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory bus between instruction
// fetch (I side) and load/store (D side). One transaction at a time is
// sequenced through IDLE -> DBUS/IBUS -> DONE -> IDLE. Byte enables and
// write-lane replication for stores are generated here.
//
// Handshake: a requester raises I_REQ/DAS and holds it until its one-cycle
// ACK pulse; the arbiter raises M_REQ with stable address/data/enables and
// holds it until the memory answers with M_RDY (data/error valid with M_RDY).
//
// Optional build macro ARB_TIMEOUT_EN: adds an 8-bit wait counter that aborts
// a bus transaction after TIMEOUT_CYC M_REQ cycles without M_RDY, returning
// ERR=1 and data=0. Without it the FSM waits for M_RDY indefinitely.
module mem_port_arbiter #(
    parameter int DBURST_MAX  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        I_REQ,
    input  logic [31:0] IADDR,
    output logic [31:0] IDATA,
    output logic        I_ACK,
    output logic        I_ERR,
    input  logic        DAS,
    input  logic        DWR,
    input  logic [31:0] DADDR,
    input  logic [31:0] DATAO,
    input  logic [2:0]  DLEN,
    output logic [31:0] DATAI,
    output logic        D_ACK,
    output logic        BERR,
    output logic        HLT,
    output logic        M_REQ,
    output logic        M_WR,
    output logic [31:0] M_ADDR,
    output logic [31:0] M_WDATA,
    output logic [3:0]  M_BE,
    input  logic [31:0] M_RDATA,
    input  logic        M_RDY,
    input  logic        M_ERR,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DBUS = 2'd1,
        ST_IBUS = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0] BURST_LIM = 4'(DBURST_MAX);

    // Reject configurations the counters cannot represent.
    if (DBURST_MAX < 1 || DBURST_MAX > 15 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_cfg
        $error("mem_port_arbiter: DBURST_MAX must be 1..15 and TIMEOUT_CYC 1..255");
    end

    state_t      state_q, state_d;
    logic [3:0]  bcnt_q, bcnt_d;
    logic        m_req_q, m_req_d;
    logic        m_wr_q, m_wr_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [3:0]  m_be_q, m_be_d;
    logic        i_ack_q, i_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        i_err_q, i_err_d;
    logic        berr_q, berr_d;
    logic [31:0] idata_q, idata_d;
    logic [31:0] datai_q, datai_d;

    logic        d_bad;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic        bus_done;
    logic [31:0] bus_data;
    logic        bus_err;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0]  wcnt_q, wcnt_d;
`endif

    // Fetches are word aligned by definition; the low address bits carry nothing.
    logic unused_iaddr_bits;
    assign unused_iaddr_bits = ^IADDR[1:0];

    // Decode the data request: alignment check, byte enables, lane replication.
    always_comb begin
        d_bad   = 1'b0;
        d_be    = 4'hF;
        d_wdata = DATAO;
        case (DLEN)
            3'd1: begin
                d_be    = 4'b0001 << DADDR[1:0];
                d_wdata = {4{DATAO[7:0]}};
            end
            3'd2: begin
                d_bad   = DADDR[0];
                d_be    = 4'b0011 << {DADDR[1], 1'b0};
                d_wdata = {2{DATAO[15:0]}};
            end
            3'd4: begin
                d_bad   = |DADDR[1:0];
            end
            default: begin
                d_bad   = 1'b1;
            end
        endcase
        if (!DWR) begin
            d_be = 4'hF;
        end
    end

    // Decide whether the current bus transaction ends this cycle and with what result.
    always_comb begin
`ifdef ARB_TIMEOUT_EN
        bus_done = M_RDY | (wcnt_q == TO_LAST);
        bus_data = M_RDY ? M_RDATA : 32'h0;
        bus_err  = M_RDY ? M_ERR : 1'b1;
`else
        bus_done = M_RDY;
        bus_data = M_RDATA;
        bus_err  = M_ERR;
`endif
    end

    // Next-state logic: arbitration in IDLE, completion in the bus states.
    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        m_req_d   = m_req_q;
        m_wr_d    = m_wr_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_be_d    = m_be_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_err_d   = i_err_q;
        berr_d    = berr_q;
        idata_d   = idata_q;
        datai_d   = datai_q;
`ifdef ARB_TIMEOUT_EN
        wcnt_d    = wcnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (DAS && !(I_REQ && (bcnt_q == BURST_LIM))) begin
                    // Only D grants made while a fetch is waiting count toward starvation.
                    bcnt_d = I_REQ ? (bcnt_q + 4'd1) : 4'd0;
                    if (d_bad) begin
                        state_d = ST_DONE;
                        d_ack_d = 1'b1;
                        berr_d  = 1'b1;
                    end else begin
                        state_d   = ST_DBUS;
                        m_req_d   = 1'b1;
                        m_wr_d    = DWR;
                        m_addr_d  = {DADDR[31:2], 2'b00};
                        m_be_d    = d_be;
                        m_wdata_d = d_wdata;
`ifdef ARB_TIMEOUT_EN
                        wcnt_d    = 8'd0;
`endif
                    end
                end else if (I_REQ) begin
                    state_d  = ST_IBUS;
                    bcnt_d   = 4'd0;
                    m_req_d  = 1'b1;
                    m_wr_d   = 1'b0;
                    m_addr_d = {IADDR[31:2], 2'b00};
                    m_be_d   = 4'hF;
`ifdef ARB_TIMEOUT_EN
                    wcnt_d   = 8'd0;
`endif
                end else begin
                    bcnt_d = 4'd0;
                end
            end
            ST_DBUS, ST_IBUS: begin
                if (bus_done) begin
                    state_d = ST_DONE;
                    m_req_d = 1'b0;
                    if (state_q == ST_DBUS) begin
                        d_ack_d = 1'b1;
                        datai_d = bus_data;
                        berr_d  = bus_err;
                    end else begin
                        i_ack_d = 1'b1;
                        idata_d = bus_data;
                        i_err_d = bus_err;
                    end
                end else begin
`ifdef ARB_TIMEOUT_EN
                    wcnt_d = wcnt_q + 8'd1;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q   <= ST_IDLE;
            bcnt_q    <= 4'd0;
            m_req_q   <= 1'b0;
            m_wr_q    <= 1'b0;
            m_addr_q  <= 32'h0;
            m_wdata_q <= 32'h0;
            m_be_q    <= 4'h0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_err_q   <= 1'b0;
            berr_q    <= 1'b0;
            idata_q   <= 32'h0;
            datai_q   <= 32'h0;
`ifdef ARB_TIMEOUT_EN
            wcnt_q    <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            m_req_q   <= m_req_d;
            m_wr_q    <= m_wr_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_be_q    <= m_be_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_err_q   <= i_err_d;
            berr_q    <= berr_d;
            idata_q   <= idata_d;
            datai_q   <= datai_d;
`ifdef ARB_TIMEOUT_EN
            wcnt_q    <= wcnt_d;
`endif
        end
    end

    assign IDATA       = idata_q;
    assign I_ACK       = i_ack_q;
    assign I_ERR       = i_err_q;
    assign DATAI       = datai_q;
    assign D_ACK       = d_ack_q;
    assign BERR        = berr_q;
    assign M_REQ       = m_req_q;
    assign M_WR        = m_wr_q;
    assign M_ADDR      = m_addr_q;
    assign M_WDATA     = m_wdata_q;
    assign M_BE        = m_be_q;
    assign dbg_state_o = state_q;

    // Stall the core while either side has an unanswered request.
    assign HLT = ~RES & ((I_REQ & ~i_ack_q) | (DAS & ~d_ack_q));

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one unified single-ported memory bus between the core's instruction-fetch side and its load/store side. Sits between myCPU (IADDR/IDATA and DADDR/DATAO/DATAI/DLEN/DRD/DWR/DAS) and the SoC memory. It sequences one transaction at a time through a small FSM and generates byte enables and write-lane replication. It drives the core's pipeline stall (HLT) while either side is waiting.

Parameters:
DBURST_MAX, 4, max consecutive D grants while I_REQ is pending before I is forced (1..15)
TIMEOUT_CYC, 255, M_REQ cycles without M_RDY before abort (used only with ARB_TIMEOUT_EN)

Ports:
CLK  in  1  clock; all logic on posedge
RES  in  1  synchronous reset, active-high
I_REQ  in  1  fetch request; held until I_ACK
IADDR  in  32  fetch address (word aligned; bits[1:0] ignored)
IDATA  out  32  fetched word, valid with I_ACK
I_ACK  out  1  one-cycle fetch completion pulse
I_ERR  out  1  fetch error, valid with I_ACK
DAS  in  1  data request; held until D_ACK
DWR  in  1  1=store, 0=load
DADDR  in  32  data byte address
DATAO  in  32  store data, right-aligned
DLEN  in  3  1=byte, 2=half, 4=word
DATAI  out  32  raw loaded word, valid with D_ACK
D_ACK  out  1  one-cycle data completion pulse
BERR  out  1  data error, valid with D_ACK
HLT  out  1  pipeline stall to core
M_REQ  out  1  memory request; held until M_RDY
M_WR  out  1  memory write
M_ADDR  out  32  word address ({addr[31:2],2'b00})
M_WDATA  out  32  lane-replicated write data
M_BE  out  4  byte enables (all ones on read)
M_RDATA  in  32  read data, valid with M_RDY
M_RDY  in  1  transfer complete this cycle
M_ERR  in  1  bus error, valid with M_RDY

Behaviour:
- Reset (RES=1 at posedge): state IDLE; M_REQ, M_WR, I_ACK, D_ACK, I_ERR, BERR = 0; IDATA, DATAI, M_ADDR, M_WDATA = 0; M_BE = 0; burst counter = 0. HLT = 0 while RES=1.
- States: IDLE, DBUS, IBUS, DONE.
- IDLE arbitration, evaluated each cycle while no ACK is pulsing:
  - DAS and not (I_REQ and bcnt==DBURST_MAX) -> DBUS, bcnt++.
  - else I_REQ -> IBUS, bcnt=0.
  - else stay; bcnt=0 when I_REQ=0.
  - D wins simultaneous requests unless the starvation limit is hit.
- Entering a bus state registers M_REQ=1 plus M_ADDR/M_WR/M_WDATA/M_BE. These stay stable until M_RDY.
- BE rules:
  - byte: 0001<<a[1:0]
  - half: 0011<<{a[1],0}
  - word: 1111
  - reads: 1111
- Write data: byte -> {4{DATAO[7:0]}}; half -> {2{DATAO[15:0]}}; word -> DATAO.
- Misaligned data requests (half with a[0]=1, word with a[1:0]!=0) and illegal DLEN are rejected: no M_REQ; next cycle D_ACK=1, BERR=1, DATAI unchanged.
- M_RDY=1 in a bus state: M_REQ drops at the next edge, which also registers IDATA/DATAI=M_RDATA and I_ERR/BERR=M_ERR, pulses the matching ACK for exactly one cycle, and moves to DONE. DONE returns to IDLE unconditionally. This gives min. latency REQ->ACK = 2 cycles (M_RDY in first M_REQ cycle), with no back-to-back grant on the ACK cycle.
- HLT = (I_REQ & ~I_ACK) | (DAS & ~D_ACK), combinational, gated to 0 during RES.
- A request deasserted mid-transaction does not abort it; the transaction completes and the ACK still pulses.
- RES mid-transaction: M_REQ low after that edge, no ACK issued, all state cleared.

Optional Feature:
ARB_TIMEOUT_EN: defined -> an 8-bit wait counter counts M_REQ cycles. When it reaches TIMEOUT_CYC with no M_RDY, M_REQ drops, the matching ACK pulses with ERR=1 and data=0, and the FSM goes to DONE. Not defined -> no counter; the FSM waits for M_RDY indefinitely.

Test Plan:
- Reset, I_REQ=1 IADDR=0x100, M_RDY=1 with M_RDATA=0x00000013 on the first M_REQ cycle -> M_ADDR=0x100, M_BE=1111; I_ACK at cycle 2 with IDATA=0x13; HLT=1 cycles 0-1 only.
- I_REQ (0x104) and store byte DADDR=0x2003 DATAO=0xAB same cycle -> D first: M_WR=1, M_ADDR=0x2000, M_BE=1000, M_WDATA=0xABABABAB; after D_ACK and DONE, I is granted.
- DAS held for back-to-back loads with I_REQ pending, DBURST_MAX=4 -> four D grants, fifth grant to I, then D resumes.
- Word load DADDR=0x2002 -> no M_REQ; D_ACK=1 and BERR=1 one cycle later. Half store 0x2002 DATAO=0x1234 -> M_BE=1100, M_WDATA=0x12341234.
- M_RDY held low, TIMEOUT_CYC=8, macro defined -> ACK+ERR after 8 M_REQ cycles, data=0. Macro undefined -> M_REQ still high at cycle 100.
- RES pulsed during a D transfer with M_RDY low -> M_REQ=0, D_ACK never pulses, a new I_REQ is granted normally afterwards.
